demux_stream: RTL and testbench

- Parametrised N-way stream demultiplexer, successor to the 1-to-4 enable demux.
- Routes a WIDTH-bit input stream to one of CHANNELS outputs, each behind a single-entry output register with a valid/ready handshake.
- Channel is picked by an explicit select or by an internal round-robin pointer.
- Out-of-range selects are counted and their data dropped.
- Sits between button/switch front-end logic and per-channel consumers (display digits, LED banks).

---
 rtl/demux_stream.sv | 89 ++++++++
 tb/tb_demux_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// N-way stream demultiplexer: one input stream steered by select or round-robin
// pointer into per-channel single-entry output registers with valid/ready.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto_mode,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [SEL_W-1:0]          cur_chan,
    output logic [7:0]                err_cnt
);

    localparam logic [SEL_W:0]   CHAN_LIM  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [SEL_W-1:0]          rrPtr_p0;
    logic [CHANNELS-1:0]       bufVld_p0;
    logic [CHANNELS*WIDTH-1:0] bufData_p0;
    logic [7:0]                errCnt_p0;
    logic [SEL_W-1:0]          target;
    logic                      inRange;
    logic                      accept;
    logic                      fill;

    // Target selection and ready: depends only on buffer state, out_ready, sel, auto_mode.
    always_comb begin
        target   = auto_mode ? rrPtr_p0 : sel;
        inRange  = ({1'b0, target} < CHAN_LIM);
        in_ready = 1'b1;
        if (inRange) begin
            in_ready = !bufVld_p0[target] || out_ready[target];
        end
    end

    assign accept = in_valid && in_ready;
    assign fill   = accept && inRange;

    // Stage p0: channel buffers; empty buffers always present zero data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bufVld_p0  <= '0;
            bufData_p0 <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (fill && (target == SEL_W'(i))) begin
                    bufVld_p0[i]                <= 1'b1;
                    bufData_p0[i*WIDTH +: WIDTH] <= in_data;
                end else if (bufVld_p0[i] && out_ready[i]) begin
                    bufVld_p0[i]                <= 1'b0;
                    bufData_p0[i*WIDTH +: WIDTH] <= '0;
                end
            end
        end
    end

    // Pointer only moves on an accepted auto-mode beat, so it stalls on a blocked channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rrPtr_p0  <= '0;
            errCnt_p0 <= '0;
        end else begin
            if (accept && auto_mode) begin
                rrPtr_p0 <= (rrPtr_p0 == LAST_CHAN) ? '0 : rrPtr_p0 + SEL_W'(1);
            end
            if (accept && !inRange) begin
                errCnt_p0 <= satInc(errCnt_p0);
            end
        end
    end

    assign out_data  = bufData_p0;
    assign out_valid = bufVld_p0;
    assign cur_chan  = target;
    assign err_cnt   = errCnt_p0;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  inData;
    logic        inValid;
    logic [1:0]  sel;
    logic        autoMode;
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;

    logic        inRdy4, inRdy3;
    logic [31:0] outData4;
    logic [23:0] outData3;
    logic [3:0]  outValid4;
    logic [2:0]  outValid3;
    logic [1:0]  curChan4, curChan3;
    logic [7:0]  errCnt4, errCnt3;

    int nChecks = 0;
    int nPass = 0;
    bit cmpEn = 1'b0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
        .in_ready(inRdy4), .sel(sel), .auto_mode(autoMode), .out_data(outData4),
        .out_valid(outValid4), .out_ready(rdy4), .cur_chan(curChan4), .err_cnt(errCnt4)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
        .in_ready(inRdy3), .sel(sel), .auto_mode(autoMode), .out_data(outData3),
        .out_valid(outValid3), .out_ready(rdy3), .cur_chan(curChan3), .err_cnt(errCnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: index 0 is the 4-channel instance, index 1 the 3-channel one.
    int         chn [2] = '{4, 3};
    bit         mVld [2][4];
    logic [7:0] mData [2][4];
    int         mPtr [2];
    int         mErr [2];

    function automatic int mTarget(int d);
        return autoMode ? mPtr[d] : int'(sel);
    endfunction

    function automatic bit mOutRdy(int d, int c);
        return (d == 0) ? rdy4[c] : ((c < 3) ? rdy3[c] : 1'b0);
    endfunction

    function automatic bit mInRdy(int d);
        int t = mTarget(d);
        if (t >= chn[d]) return 1'b1;
        return !mVld[d][t] || mOutRdy(d, t);
    endfunction

    function automatic bit mAcc(int d);
        return inValid && mInRdy(d);
    endfunction

    function automatic bit mFill(int d, int c);
        return mAcc(d) && (mTarget(d) == c) && (c < chn[d]);
    endfunction

    function automatic bit mNextVld(int d, int c);
        if (mFill(d, c)) return 1'b1;
        if (mVld[d][c] && mOutRdy(d, c)) return 1'b0;
        return mVld[d][c];
    endfunction

    function automatic logic [7:0] mNextData(int d, int c);
        if (mFill(d, c)) return inData;
        if (mVld[d][c] && mOutRdy(d, c)) return 8'h00;
        return mData[d][c];
    endfunction

    function automatic int mNextPtr(int d);
        return (mAcc(d) && autoMode) ? (mPtr[d] + 1) % chn[d] : mPtr[d];
    endfunction

    function automatic int mNextErr(int d);
        if (mAcc(d) && mTarget(d) >= chn[d]) return (mErr[d] >= 255) ? 255 : mErr[d] + 1;
        return mErr[d];
    endfunction

    function automatic logic [31:0] mOutData(int d);
        logic [31:0] r = '0;
        for (int c = 0; c < chn[d]; c++) r[c*8 +: 8] = mData[d][c];
        return r;
    endfunction

    function automatic logic [31:0] mOutValid(int d);
        logic [31:0] r = '0;
        for (int c = 0; c < chn[d]; c++) r[c] = mVld[d][c];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                mVld[d][c]  <= reset_n ? mNextVld(d, c) : 1'b0;
                mData[d][c] <= reset_n ? mNextData(d, c) : 8'h00;
            end
            mPtr[d] <= reset_n ? mNextPtr(d) : 0;
            mErr[d] <= reset_n ? mNextErr(d) : 0;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            chk("m4_in_ready", 32'(inRdy4), 32'(mInRdy(0)));
            chk("m4_cur_chan", 32'(curChan4), 32'(mTarget(0)));
            chk("m4_out_valid", 32'(outValid4), mOutValid(0));
            chk("m4_out_data", outData4, mOutData(0));
            chk("m4_err_cnt", 32'(errCnt4), 32'(mErr[0]));
            chk("m3_in_ready", 32'(inRdy3), 32'(mInRdy(1)));
            chk("m3_cur_chan", 32'(curChan3), 32'(mTarget(1)));
            chk("m3_out_valid", 32'(outValid3), mOutValid(1));
            chk("m3_out_data", 32'(outData3), mOutData(1));
            chk("m3_err_cnt", 32'(errCnt3), 32'(mErr[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; inValid = 1'b0; inData = 8'h00; sel = 2'd0;
        autoMode = 1'b0; rdy4 = 4'h0; rdy3 = 3'h0;
        step();
        step();
        cmpEn = 1'b1;
        chk("rst_out_valid", 32'(outValid4), 32'h0);
        chk("rst_out_data", outData4, 32'h0);
        chk("rst_err_cnt", 32'(errCnt4), 32'h0);

        // Basic routing to channel 2
        reset_n = 1'b1; sel = 2'd2; inData = 8'hA5; inValid = 1'b1;
        #1 chk("basic_ready_before", 32'(inRdy4), 32'h1);
        step();
        inValid = 1'b0;
        #1;
        chk("basic_out_valid", 32'(outValid4), 32'h4);
        chk("basic_out_data", outData4, 32'h00A5_0000);
        chk("basic_ready_full", 32'(inRdy4), 32'h0);

        // Throughput on channel 1 with draining consumer
        sel = 2'd1; rdy4 = 4'b0010; rdy3 = 3'b010;
        for (int k = 1; k <= 4; k++) begin
            inData = 8'(k); inValid = 1'b1;
            #1 chk("tput_ready", 32'(inRdy4), 32'h1);
            step();
            chk("tput_data", 32'(outData4[15:8]), 32'(k));
        end
        rdy4 = 4'h0; rdy3 = 3'h0; inData = 8'h55;
        #1 chk("bp_ready", 32'(inRdy4), 32'h0);
        step();
        chk("bp_hold", 32'(outData4[15:8]), 32'h04);
        inValid = 1'b0; rdy4 = 4'hF; rdy3 = 3'h7;
        step();
        chk("drain_valid", 32'(outValid4), 32'h0);
        chk("drain_data", outData4, 32'h0);

        // Round-robin over all four channels with wrap
        autoMode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            inData = 8'(8'h10 + k); inValid = 1'b1;
            #1 chk("rr_cur_chan", 32'(curChan4), 32'(k % 4));
            step();
            chk("rr_valid", 32'(outValid4), 32'(1) << (k % 4));
            chk("rr_data", outData4, 32'(8'h10 + k) << (8 * (k % 4)));
        end

        // Channel 2 blocked: pointer must stall at 2
        rdy4 = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            inData = 8'(8'h20 + k);
            step();
        end
        inData = 8'h24;
        #1;
        chk("stall_ready", 32'(inRdy4), 32'h0);
        chk("stall_cur_chan", 32'(curChan4), 32'h2);
        step();
        chk("stall_ptr_held", 32'(curChan4), 32'h2);
        chk("stall_data", 32'(outData4[23:16]), 32'h20);

        // Temporary switch to explicit select, pointer keeps its value
        autoMode = 1'b0; sel = 2'd0; inData = 8'h77;
        #1;
        chk("mode_cur_chan", 32'(curChan4), 32'h0);
        chk("mode_ready", 32'(inRdy4), 32'h1);
        step();
        inValid = 1'b0; autoMode = 1'b1;
        #1;
        chk("mode_valid0", 32'(outValid4[0]), 32'h1);
        chk("mode_data0", 32'(outData4[7:0]), 32'h77);
        chk("mode_ptr_back", 32'(curChan4), 32'h2);

        // Mid-operation reset with channels 0, 2 and 3 full
        rdy4 = 4'h0; autoMode = 1'b0; sel = 2'd3; inData = 8'h33; inValid = 1'b1;
        step();
        chk("pre_rst_valid", 32'(outValid4), 32'hD);
        reset_n = 1'b0; inValid = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("midrst_valid", 32'(outValid4), 32'h0);
        chk("midrst_data", outData4, 32'h0);
        chk("midrst_err3", 32'(errCnt3), 32'h0);
        autoMode = 1'b1;
        #1 chk("midrst_ptr", 32'(curChan4), 32'h0);
        autoMode = 1'b0; sel = 2'd3; inData = 8'h3C; inValid = 1'b1;
        step();
        inValid = 1'b0;
        #1;
        chk("post_rst_valid", 32'(outValid4), 32'h8);
        chk("post_rst_data", outData4, 32'h3C00_0000);

        // Out-of-range select on the 3-channel instance
        rdy4 = 4'hF; rdy3 = 3'h7; sel = 2'd3; inValid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            inData = 8'($urandom);
            #1 chk("oor_ready", 32'(inRdy3), 32'h1);
            step();
        end
        inValid = 1'b0;
        #1;
        chk("oor_err_sat", 32'(errCnt3), 32'd255);
        chk("oor_no_valid", 32'(outValid3), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset_n  = ($urandom_range(0, 149) != 0);
            inValid  = ($urandom_range(0, 3) != 0);
            inData   = 8'($urandom);
            sel      = 2'($urandom);
            autoMode = ($urandom_range(0, 2) == 0);
            rdy4     = 4'($urandom);
            rdy3     = 3'($urandom);
            step();
        end
        inValid = 1'b0;
        step();
        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
